// File: rtl/obj_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : obj_fetch_unit
// Brief    : Fetches a tagged heap object (tag word plus decoded field count)
//            over a fixed-latency read port and returns it as one bundle.
// Revision : 1.0
// ============================================================================

module obj_fetch_unit #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_FIELDS   = 3,
    parameter int READ_LATENCY = 1,
    parameter int TAG_NUMBER   = 1,
    parameter int TAG_CONS     = 2,
    parameter int TAG_FUNC     = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic [1:0]                         err_code,
    output logic [DATA_WIDTH-1:0]              tag,
    output logic [$clog2(MAX_FIELDS+1)-1:0]    nfields,
    output logic [MAX_FIELDS*DATA_WIDTH-1:0]   fields,
    output logic                               mem_re,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [DATA_WIDTH-1:0]              mem_rdata,
    input  logic                               mem_error
);

    localparam int c_NF_W  = $clog2(MAX_FIELDS + 1);
    localparam int c_CNT_W = $clog2(READ_LATENCY + MAX_FIELDS + 2);
    localparam int c_AW1   = ADDR_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_LAT = c_CNT_W'(READ_LATENCY);
    localparam logic [c_CNT_W-1:0] c_ONE = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TAG_WAIT = 3'd1,
        S_FIELDS   = 3'd2,
        S_DONE     = 3'd3,
        S_ERR      = 3'd4
    } state_t;

    state_t                          r_state;
    logic [ADDR_WIDTH-1:0]           r_base;
    logic [c_CNT_W-1:0]              r_cnt;
    logic                            r_done;
    logic                            r_err;
    logic [1:0]                      r_err_code;
    logic [DATA_WIDTH-1:0]           r_tag;
    logic [c_NF_W-1:0]               r_nfields;
    logic [MAX_FIELDS*DATA_WIDTH-1:0] r_fields;

    logic [2:0]                      w_dec_n;
    logic                            w_dec_ok;
    logic [ADDR_WIDTH:0]             w_end_addr;
    logic                            w_ovf;
    logic [c_CNT_W-1:0]              w_nf_ext;
    logic                            w_issue;
    logic                            w_capture;
    logic [c_CNT_W-1:0]              w_cap_idx;
    logic                            w_last;

    // Tag decode and end-of-object overflow check on the word arriving now.
    always_comb begin
        w_dec_n = 3'd0;
        if (mem_rdata == DATA_WIDTH'(TAG_NUMBER))
            w_dec_n = 3'd1;
        else if (mem_rdata == DATA_WIDTH'(TAG_CONS))
            w_dec_n = 3'd2;
        else if (mem_rdata == DATA_WIDTH'(TAG_FUNC))
            w_dec_n = 3'd3;
        w_dec_ok   = (w_dec_n != 3'd0) && (int'(w_dec_n) <= MAX_FIELDS);
        w_end_addr = {1'b0, r_base} + c_AW1'(w_dec_n);
        w_ovf      = w_end_addr[ADDR_WIDTH];
    end

    // In FIELDS, r_cnt counts cycles: issue slot i at r_cnt == i,
    // its data returns at r_cnt == i + READ_LATENCY.
    always_comb begin
        w_nf_ext  = c_CNT_W'(r_nfields);
        w_issue   = (r_state == S_FIELDS) && (r_cnt < w_nf_ext);
        w_capture = (r_state == S_FIELDS) && (r_cnt >= c_LAT);
        w_cap_idx = r_cnt - c_LAT;
        w_last    = w_capture && (w_cap_idx == (w_nf_ext - c_ONE));
    end

    always_comb begin
        mem_re   = 1'b0;
        mem_addr = '0;
        if (!rst) begin
            if ((r_state == S_IDLE) && start) begin
                mem_re   = 1'b1;
                mem_addr = base_addr;
            end else if (w_issue) begin
                mem_re   = 1'b1;
                mem_addr = r_base + ADDR_WIDTH'(r_cnt) + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_tag      <= '0;
            r_nfields  <= '0;
            r_fields   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base     <= base_addr;
                        r_tag      <= '0;
                        r_nfields  <= '0;
                        r_fields   <= '0;
                        r_err_code <= 2'd0;
                        r_cnt      <= c_ONE;
                        r_state    <= S_TAG_WAIT;
                    end
                end
                S_TAG_WAIT: begin
                    if (mem_error) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                        r_state    <= S_ERR;
                    end else if (r_cnt == c_LAT) begin
                        if (!w_dec_ok) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'd0;
                            r_state    <= S_ERR;
                        end else if (w_ovf) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'd2;
                            r_state    <= S_ERR;
                        end else begin
                            r_tag     <= mem_rdata;
                            r_nfields <= c_NF_W'(w_dec_n);
                            r_cnt     <= '0;
                            r_state   <= S_FIELDS;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                S_FIELDS: begin
                    if (mem_error) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                        r_state    <= S_ERR;
                    end else begin
                        for (int i = 0; i < MAX_FIELDS; i++) begin
                            if (w_capture && (w_cap_idx == c_CNT_W'(i)))
                                r_fields[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                        end
                        r_cnt <= r_cnt + c_ONE;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == S_TAG_WAIT) || (r_state == S_FIELDS);
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign tag      = r_tag;
    assign nfields  = r_nfields;
    assign fields   = r_fields;

endmodule

`default_nettype wire

// File: tb/tb_obj_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_obj_fetch_unit
// Brief    : Randomised scoreboard bench for obj_fetch_unit with a cycle-level
//            reference model and an ideal fixed-latency memory.
// Revision : 1.0
// ============================================================================

module tb_obj_fetch_unit;

    localparam int LAT  = 2;
    localparam int MAXF = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic        busy, done, err, mem_re, mem_error;
    logic [1:0]  err_code;
    logic [15:0] tag, mem_addr, mem_rdata;
    logic [1:0]  nfields;
    logic [47:0] fields;

    obj_fetch_unit #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_FIELDS(MAXF), .READ_LATENCY(LAT),
        .TAG_NUMBER(1), .TAG_CONS(2), .TAG_FUNC(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .tag(tag), .nfields(nfields), .fields(fields),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        int          code;
        int          cyc;
        logic [15:0] tag;
        int          nf;
        logic [47:0] flds;
    } outcome_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
    } rd_t;

    outcome_t    exp_q[$];
    rd_t         rd_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    logic [15:0] mem [0:65535];
    logic [15:0] rd_pipe [LAT];

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal memory: unread cycles return noise so stale sampling shows up.
    always @(posedge clk) begin
        rd_pipe[0] <= mem_re ? mem[mem_addr] : 16'($urandom);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string where);
        chk({where, "_busy"}, busy, 0);
        chk({where, "_done"}, done, 0);
        chk({where, "_err"}, err, 0);
        chk({where, "_mem_re"}, mem_re, 0);
        chk({where, "_err_code"}, err_code, 0);
        chk({where, "_tag"}, tag, 0);
        chk({where, "_nfields"}, nfields, 0);
        chk({where, "_fields"}, fields, 0);
        chk({where, "_mem_addr"}, mem_addr, 0);
    endtask

    // Monitor: every read strobe and every done/err pulse must match the next expectation.
    always @(negedge clk) begin : monitor
        rd_t      r;
        outcome_t o;
        if (mon_en) begin
            if (mem_re) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: addr %h at cycle %0d, none expected", mem_addr, cyc);
                end else begin
                    r = rd_q.pop_front();
                    chk("read_cycle", cyc, r.cyc);
                    chk("read_addr", mem_addr, r.addr);
                end
            end
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_outcome: done=%0b err=%0b at cycle %0d, none expected", done, err, cyc);
                end else begin
                    o = exp_q.pop_front();
                    chk("outcome_err", err, o.is_err);
                    chk("outcome_done", done, !o.is_err);
                    chk("outcome_cycle", cyc, o.cyc);
                    if (o.is_err) chk("err_code", err_code, o.code);
                    chk("tag", tag, o.tag);
                    chk("nfields", nfields, o.nf);
                    chk("fields", fields, o.flds);
                    chk("busy_at_end", busy, 0);
                end
            end
        end
    end

    // Reference model: timings follow directly from L, n and the abort cycle.
    task automatic predict(input logic [15:0] base, input int s, input int merr, input int rst_off);
        outcome_t o;
        rd_t      r;
        logic [15:0] tw;
        int n, last_busy, abort;
        bit ok, merr_hit;
        tw = mem[base];
        n  = (tw == 16'd1) ? 1 : (tw == 16'd2) ? 2 : (tw == 16'd3) ? 3 : 0;
        if (n > MAXF) n = 0;
        ok = (n != 0) && (int'(base) + n <= 65535);
        o = '{is_err: 0, code: 0, cyc: 0, tag: 16'h0, nf: 0, flds: 48'h0};
        if (!ok) begin
            o.is_err = 1; o.code = (n == 0) ? 0 : 2; o.cyc = LAT + 1; last_busy = LAT;
        end else begin
            o.tag = tw; o.nf = n; o.cyc = 2*LAT + n + 1; last_busy = 2*LAT + n;
            for (int i = 0; i < n; i++) o.flds[i*16 +: 16] = mem[int'(base) + 1 + i];
        end
        merr_hit = (merr >= 1) && (merr <= last_busy);
        if (merr_hit) begin
            o.is_err = 1; o.code = 1; o.cyc = merr + 1;
            if (merr <= LAT) begin o.tag = 16'h0; o.nf = 0; end
            for (int i = 0; i < MAXF; i++)
                if (2*LAT + 1 + i >= merr) o.flds[i*16 +: 16] = 16'h0;
        end
        abort = (rst_off > 0) ? rst_off : (merr_hit ? merr + 1 : 1000);
        r.cyc = s; r.addr = base; rd_q.push_back(r);
        if (ok)
            for (int i = 0; i < n; i++)
                if (LAT + 1 + i < abort) begin
                    r.cyc = s + LAT + 1 + i; r.addr = base + 16'(1 + i); rd_q.push_back(r);
                end
        o.cyc = o.cyc + s;
        if (rst_off <= 0) exp_q.push_back(o);
    endtask

    task automatic set_obj(input logic [15:0] base, input logic [15:0] tw,
                           input logic [15:0] f0, input logic [15:0] f1, input logic [15:0] f2);
        mem[base] = tw;
        if (int'(base) + 1 <= 65535) mem[int'(base) + 1] = f0;
        if (int'(base) + 2 <= 65535) mem[int'(base) + 2] = f1;
        if (int'(base) + 3 <= 65535) mem[int'(base) + 3] = f2;
    endtask

    // Called in an IDLE cycle (just after a clock edge); returns in the next IDLE cycle.
    task automatic run_obj(input logic [15:0] base, input int merr_off, input int rst_off);
        int  s;
        bit  finished;
        s = cyc;
        predict(base, s, merr_off, rst_off);
        start = 1'b1; base_addr = base;
        finished = 0;
        for (int k = 1; k <= 200 && !finished; k++) begin
            @(posedge clk); #1;
            start = 1'b0; mem_error = 1'b0; rst = 1'b0;
            if (rst_off > 0 && k == rst_off + 1) begin
                check_zero("mid_reset");
                finished = 1;
            end else if (done || err) begin
                @(posedge clk); #1;
                finished = 1;
            end else if (k == rst_off) begin
                rst = 1'b1;
            end else begin
                if (k == merr_off) mem_error = 1'b1;
                if (busy && $urandom_range(0, 3) == 0) begin
                    start = 1'b1; base_addr = 16'($urandom);
                end
            end
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL timeout: base %h no outcome within 200 cycles, required done or err", base);
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
            exp_q.delete(); rd_q.delete();
        end
    endtask

    initial begin
        logic [15:0] b, t;
        int m;
        rst = 1'b1; start = 1'b0; base_addr = 16'h0; mem_error = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0; mon_en = 1;

        set_obj(16'h0010, 16'd2, 16'h0020, 16'h0030, 16'h1111);
        run_obj(16'h0010, -1, 0);
        set_obj(16'h0040, 16'd3, 16'h000A, 16'h000B, 16'h000C);
        run_obj(16'h0040, -1, 0);
        set_obj(16'h0008, 16'd7, 16'h1, 16'h2, 16'h3);
        run_obj(16'h0008, -1, 0);
        set_obj(16'hFFFE, 16'd2, 16'h4444, 16'h5555, 16'h6666);
        run_obj(16'hFFFE, -1, 0);
        set_obj(16'hFFFE, 16'd1, 16'h1234, 16'h5555, 16'h6666);
        run_obj(16'hFFFE, -1, 0);
        set_obj(16'h0020, 16'd2, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        run_obj(16'h0020, LAT + 2, 0);
        set_obj(16'h0030, 16'd1, 16'h7777, 16'h8888, 16'h9999);
        run_obj(16'h0030, -1, 0);
        set_obj(16'h0050, 16'd3, 16'hD001, 16'hD002, 16'hD003);
        run_obj(16'h0050, -1, LAT + 2);
        run_obj(16'h0040, -1, 0);

        for (int it = 0; it < 60; it++) begin
            b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3)) : 16'($urandom);
            case ($urandom_range(0, 4))
                0: t = 16'($urandom);
                1: t = 16'd1;
                2: t = 16'd2;
                3: t = 16'd3;
                default: t = 16'd0;
            endcase
            m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2*LAT + 4)) : -1;
            set_obj(b, t, 16'($urandom), 16'($urandom), 16'($urandom));
            run_obj(b, m, 0);
        end

        repeat (10) @(posedge clk);
        #1;
        chk("leftover_outcomes", exp_q.size(), 0);
        chk("leftover_reads", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
